// File: rtl/rr_port_drain_sched.sv
`default_nettype none
// ============================================================================
// Module   : rr_port_drain_sched
// Brief    : Round-robin drain of four router output ports onto one tagged
//            byte stream (SOP/EOP, source port) with a drained-packet counter.
// Revision : 1.0  initial release
// ============================================================================
module rr_port_drain_sched #(
   parameter int CNT_W      = 16,
   parameter int GAP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       newdata_len_1,
   input  logic [4:0]       newdata_len_2,
   input  logic [4:0]       newdata_len_3,
   input  logic [4:0]       newdata_len_4,
   input  logic [7:0]       data_out_1,
   input  logic [7:0]       data_out_2,
   input  logic [7:0]       data_out_3,
   input  logic [7:0]       data_out_4,
   input  logic             sink_ready,
   output logic             proceed_1,
   output logic             proceed_2,
   output logic             proceed_3,
   output logic             proceed_4,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic [1:0]       out_port,
   output logic             out_sop,
   output logic             out_eop,
   output logic             busy,
   output logic [CNT_W-1:0] pkt_cnt
);

   localparam logic [2:0] C_GAP_LAST = 3'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_RECV  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       cur_q, cur_d;
   logic [4:0]       len_q, len_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [2:0]       gap_q, gap_d;
   logic [3:0]       proceed_q, proceed_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       out_data_q, out_data_d;
   logic [1:0]       out_port_q, out_port_d;
   logic             out_sop_q, out_sop_d;
   logic             out_eop_q, out_eop_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

   logic [3:0]       w_req;
   logic [4:0]       w_len  [4];
   logic [7:0]       w_data [4];
   logic             w_any;
   logic [1:0]       w_win;
   logic             w_last;

   assign w_len[0]  = newdata_len_1;
   assign w_len[1]  = newdata_len_2;
   assign w_len[2]  = newdata_len_3;
   assign w_len[3]  = newdata_len_4;
   assign w_data[0] = data_out_1;
   assign w_data[1] = data_out_2;
   assign w_data[2] = data_out_3;
   assign w_data[3] = data_out_4;
   assign w_req     = {|newdata_len_4, |newdata_len_3, |newdata_len_2, |newdata_len_1};
   assign w_last    = (cnt_q == 5'(len_q - 5'd1));

   // Scan from the farthest offset back to the pointer so the nearest requester wins.
   always_comb begin
      logic [1:0] idx;
      idx   = 2'd0;
      w_win = ptr_q;
      w_any = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr_q + 2'(i);
         if (w_req[idx]) begin
            w_win = idx;
            w_any = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cur_d       = cur_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      gap_d       = gap_q;
      proceed_d   = 4'b0000;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_port_d  = out_port_q;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      pkt_cnt_d   = pkt_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (w_any && sink_ready) begin
               state_d          = ST_GRANT;
               len_d            = w_len[w_win];
               cur_d            = w_win;
               ptr_d            = w_win + 2'd1;
               proceed_d[w_win] = 1'b1;
            end
         end
         ST_GRANT: begin
            state_d = ST_RECV;
            cnt_d   = 5'd0;
         end
         ST_RECV: begin
            out_valid_d = 1'b1;
            out_data_d  = w_data[cur_q];
            out_port_d  = cur_q;
            out_sop_d   = (cnt_q == 5'd0);
            out_eop_d   = w_last;
            if (w_last) begin
               pkt_cnt_d = pkt_cnt_q + 1'b1;
               state_d   = ST_GAP;
               gap_d     = C_GAP_LAST;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         ST_GAP: begin
            if (gap_q == 3'd0) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ptr_q       <= 2'd0;
         cur_q       <= 2'd0;
         len_q       <= 5'd0;
         cnt_q       <= 5'd0;
         gap_q       <= 3'd0;
         proceed_q   <= 4'b0000;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'd0;
         out_port_q  <= 2'd0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         busy_q      <= 1'b0;
         pkt_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cur_q       <= cur_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         proceed_q   <= proceed_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_port_q  <= out_port_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         busy_q      <= busy_d;
         pkt_cnt_q   <= pkt_cnt_d;
      end
   end

   assign proceed_1 = proceed_q[0];
   assign proceed_2 = proceed_q[1];
   assign proceed_3 = proceed_q[2];
   assign proceed_4 = proceed_q[3];
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_port  = out_port_q;
   assign out_sop   = out_sop_q;
   assign out_eop   = out_eop_q;
   assign busy      = busy_q;
   assign pkt_cnt   = pkt_cnt_q;

endmodule
`default_nettype wire
